// File: rtl/bram_sd_seq_if.sv
// ---------------------------------------------------------------------------
// bram_sd_seq_if
// Sector/format bus between the backup-RAM sequencer and the hps_io side.
//
// Signals
//   sd_lba   [31:0]  sector address driven by the sequencer
//   sd_rd            sector read request  (image -> BRAM, i.e. load)
//   sd_wr            sector write request (BRAM -> image, i.e. save)
//   sd_ack           sector acknowledge from hps_io (high while it works)
//   fmt_addr [2:0]   save-format header word index
//   fmt_we           save-format header word write strobe
//
// Modports
//   master  : sequencer side (drives requests, receives sd_ack)
//   slave   : hps_io / BRAM side (receives requests, drives sd_ack)
// ---------------------------------------------------------------------------
interface bram_sd_seq_if;
    logic [31:0] sd_lba;
    logic        sd_rd;
    logic        sd_wr;
    logic        sd_ack;
    logic [2:0]  fmt_addr;
    logic        fmt_we;

    modport master (
        output sd_lba,
        output sd_rd,
        output sd_wr,
        output fmt_addr,
        output fmt_we,
        input  sd_ack
    );

    modport slave (
        input  sd_lba,
        input  sd_rd,
        input  sd_wr,
        input  fmt_addr,
        input  fmt_we,
        output sd_ack
    );
endinterface

// File: rtl/bram_sd_seq.sv
// ---------------------------------------------------------------------------
// bram_sd_seq
// Sequences backup-RAM transfers between the dual-port save RAM (port B) and
// the hps_io SD sector interface: manual load/save, autosave when the OSD
// opens, auto-load after a cart download, and save-format header writes.
// While a load runs, bk_loading is meant to hold the console core in reset.
//
// Parameters
//   SECTORS  512-byte sectors per image (power of 2, 2..256)
//   FMT_N    16-bit header words written by a format (1..8)
//   TO_W     watchdog counter width (only used with BKSEQ_TIMEOUT_EN)
//
// Configuration macro
//   BKSEQ_TIMEOUT_EN  when defined, a transfer that sees no sd_ack edge for
//                     2**TO_W-1 cycles is aborted and bk_err is raised.
//                     When undefined, XFER waits forever and bk_err = 0.
//
// Ports
//   clk_sys      system clock
//   reset_n      asynchronous active-low reset
//   bk_ena       save image mounted and writable
//   load_req     manual load request (rising edge acts)
//   save_req     manual save request (rising edge acts)
//   autosave_en  autosave option
//   osd_status   OSD open
//   bram_wr      core wrote BRAM this cycle
//   format_req   format request (rising edge acts)
//   download     cart download active
//   img_nz       mounted image size non-zero
//   sd           sector/format bus (master modport)
//   bk_state     transfer active
//   bk_loading   load active
//   bk_pending   unsaved BRAM writes exist
//   bk_err       watchdog abort flag
// ---------------------------------------------------------------------------
module bram_sd_seq #(
    parameter int SECTORS = 16,
    parameter int FMT_N   = 4,
    parameter int TO_W    = 20
) (
    input  logic                 clk_sys,
    input  logic                 reset_n,
    input  logic                 bk_ena,
    input  logic                 load_req,
    input  logic                 save_req,
    input  logic                 autosave_en,
    input  logic                 osd_status,
    input  logic                 bram_wr,
    input  logic                 format_req,
    input  logic                 download,
    input  logic                 img_nz,
    bram_sd_seq_if.master        sd,
    output logic                 bk_state,
    output logic                 bk_loading,
    output logic                 bk_pending,
    output logic                 bk_err
);

    localparam int LBA_W = (SECTORS > 1) ? $clog2(SECTORS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_XFER   = 2'd1,
        ST_FORMAT = 2'd2
    } state_t;

    state_t             state_reg, state_next;
    logic [LBA_W-1:0]   lba_reg, lba_next;
    logic               rd_reg, rd_next;
    logic               wr_reg, wr_next;
    logic [2:0]         fmt_addr_reg, fmt_addr_next;
    logic               fmt_we_reg, fmt_we_next;
    logic               bk_state_reg, bk_state_next;
    logic               bk_loading_reg, bk_loading_next;
    logic               bk_pending_reg, bk_pending_next;
    logic               fmt_pend_reg, fmt_pend_next;
    logic               auto_trig_d_reg;
    logic               download_d_reg;
    logic               ack_d_reg;

    // Request edge detectors: bit 0 load, bit 1 save, bit 2 format.
    logic [2:0]         req_in;
    logic [2:0]         req_d_reg;
    logic [2:0]         req_edge;

    assign req_in = {format_req, save_req, load_req};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_req_edge
            always_ff @(posedge clk_sys or negedge reset_n) begin
                if (!reset_n) begin
                    req_d_reg[gi] <= 1'b0;
                end else begin
                    req_d_reg[gi] <= req_in[gi];
                end
            end
            assign req_edge[gi] = req_in[gi] & ~req_d_reg[gi];
        end
    endgenerate

    logic load_edge, save_edge, fmt_edge;
    logic auto_trig, auto_edge, autoload_edge;
    logic ack_rise, ack_fall;
    logic pend_set;
    logic xfer_start, start_load, fmt_enter;

    assign load_edge     = req_edge[0];
    assign save_edge     = req_edge[1];
    assign fmt_edge      = req_edge[2];
    // Autosave fires once when the OSD opens with unsaved data present.
    assign auto_trig     = autosave_en & bk_pending_reg & osd_status;
    assign auto_edge     = auto_trig & ~auto_trig_d_reg;
    // Auto-load on the falling edge of a cart download.
    assign autoload_edge = download_d_reg & ~download & img_nz & bk_ena;
    assign ack_rise      = sd.sd_ack & ~ack_d_reg;
    assign ack_fall      = ~sd.sd_ack & ack_d_reg;
    // Writes made while the OSD is open are not counted as unsaved data.
    assign pend_set      = bk_ena & ~osd_status & bram_wr;

`ifdef BKSEQ_TIMEOUT_EN
    logic [TO_W-1:0]    to_cnt_reg, to_cnt_next;
    logic               bk_err_reg, bk_err_next;
`endif

    // ---------------- next-state / output logic ----------------
    always_comb begin
        state_next      = state_reg;
        lba_next        = lba_reg;
        rd_next         = rd_reg;
        wr_next         = wr_reg;
        fmt_addr_next   = fmt_addr_reg;
        fmt_we_next     = fmt_we_reg;
        bk_state_next   = bk_state_reg;
        bk_loading_next = bk_loading_reg;
        bk_pending_next = bk_pending_reg;
        fmt_pend_next   = fmt_pend_reg;
        xfer_start      = 1'b0;
        start_load      = 1'b0;
        fmt_enter       = 1'b0;
`ifdef BKSEQ_TIMEOUT_EN
        to_cnt_next     = to_cnt_reg;
        bk_err_next     = bk_err_reg;
`endif

        case (state_reg)
            ST_IDLE: begin
                if (autoload_edge) begin
                    xfer_start = 1'b1;
                    start_load = 1'b1;
                end else if (load_edge && bk_ena) begin
                    xfer_start = 1'b1;
                    start_load = 1'b1;
                end else if ((save_edge || auto_edge) && bk_ena) begin
                    xfer_start = 1'b1;
                end else if (fmt_pend_reg) begin
                    state_next    = ST_FORMAT;
                    fmt_we_next   = 1'b1;
                    fmt_addr_next = 3'd0;
                    fmt_enter     = 1'b1;
                end
            end

            ST_XFER: begin
                if (ack_rise) begin
                    rd_next = 1'b0;
                    wr_next = 1'b0;
                end else if (ack_fall) begin
                    if (lba_reg == LBA_W'(SECTORS - 1)) begin
                        state_next      = ST_IDLE;
                        bk_state_next   = 1'b0;
                        bk_loading_next = 1'b0;
                    end else begin
                        // Next sector: same direction as the transfer.
                        lba_next = lba_reg + LBA_W'(1);
                        rd_next  = bk_loading_reg;
                        wr_next  = ~bk_loading_reg;
                    end
                end
`ifdef BKSEQ_TIMEOUT_EN
                if (ack_rise || ack_fall) begin
                    to_cnt_next = '0;
                end else if (&to_cnt_reg) begin
                    state_next      = ST_IDLE;
                    rd_next         = 1'b0;
                    wr_next         = 1'b0;
                    bk_state_next   = 1'b0;
                    bk_loading_next = 1'b0;
                    bk_err_next     = 1'b1;
                end else begin
                    to_cnt_next = to_cnt_reg + TO_W'(1);
                end
`endif
            end

            ST_FORMAT: begin
                if (fmt_addr_reg == 3'(FMT_N - 1)) begin
                    state_next    = ST_IDLE;
                    fmt_we_next   = 1'b0;
                    fmt_addr_next = 3'd0;
                end else begin
                    fmt_addr_next = fmt_addr_reg + 3'd1;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase

        if (xfer_start) begin
            state_next      = ST_XFER;
            lba_next        = '0;
            bk_state_next   = 1'b1;
            bk_loading_next = start_load;
            rd_next         = start_load;
            wr_next         = ~start_load;
`ifdef BKSEQ_TIMEOUT_EN
            to_cnt_next     = '0;
            bk_err_next     = 1'b0;
`endif
        end

        // Starting a transfer saves everything, so it wins over a new write.
        if (xfer_start) begin
            bk_pending_next = 1'b0;
        end else if (pend_set) begin
            bk_pending_next = 1'b1;
        end

        // A format edge arriving on the entry cycle queues another format.
        if (fmt_enter) begin
            fmt_pend_next = 1'b0;
        end
        if (fmt_edge) begin
            fmt_pend_next = 1'b1;
        end
    end

    // ---------------- state register ----------------
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_reg       <= ST_IDLE;
            lba_reg         <= '0;
            rd_reg          <= 1'b0;
            wr_reg          <= 1'b0;
            fmt_addr_reg    <= 3'd0;
            fmt_we_reg      <= 1'b0;
            bk_state_reg    <= 1'b0;
            bk_loading_reg  <= 1'b0;
            bk_pending_reg  <= 1'b0;
            fmt_pend_reg    <= 1'b0;
            auto_trig_d_reg <= 1'b0;
            download_d_reg  <= 1'b0;
            ack_d_reg       <= 1'b0;
        end else begin
            state_reg       <= state_next;
            lba_reg         <= lba_next;
            rd_reg          <= rd_next;
            wr_reg          <= wr_next;
            fmt_addr_reg    <= fmt_addr_next;
            fmt_we_reg      <= fmt_we_next;
            bk_state_reg    <= bk_state_next;
            bk_loading_reg  <= bk_loading_next;
            bk_pending_reg  <= bk_pending_next;
            fmt_pend_reg    <= fmt_pend_next;
            auto_trig_d_reg <= auto_trig;
            download_d_reg  <= download;
            ack_d_reg       <= sd.sd_ack;
        end
    end

`ifdef BKSEQ_TIMEOUT_EN
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            to_cnt_reg <= '0;
            bk_err_reg <= 1'b0;
        end else begin
            to_cnt_reg <= to_cnt_next;
            bk_err_reg <= bk_err_next;
        end
    end
    assign bk_err = bk_err_reg;
`else
    // No watchdog: the flag can never be raised. TO_W appears here only so
    // the parameter is referenced in this build; the expression is always 0.
    assign bk_err = 1'b0 && (TO_W < 0);
`endif

    // ---------------- outputs ----------------
    assign sd.sd_lba   = 32'(lba_reg);
    assign sd.sd_rd    = rd_reg;
    assign sd.sd_wr    = wr_reg;
    assign sd.fmt_addr = fmt_addr_reg;
    assign sd.fmt_we   = fmt_we_reg;
    assign bk_state    = bk_state_reg;
    assign bk_loading  = bk_loading_reg;
    assign bk_pending  = bk_pending_reg;

endmodule

// File: tb/tb_bram_sd_seq.sv
// ---------------------------------------------------------------------------
// tb_bram_sd_seq
// Scoreboard bench for bram_sd_seq. Stimulus tasks push the expected sector
// requests / format words into queues; a monitor pops and compares whenever
// the DUT raises a sector request or a format strobe. An hps_io-like
// responder acknowledges each request 5 cycles after it appears.
// ---------------------------------------------------------------------------
module tb_bram_sd_seq;
    localparam int SECTORS = 16;
    localparam int FMT_N   = 4;
`ifdef BKSEQ_TIMEOUT_EN
    localparam int TO_W    = 8;
`else
    localparam int TO_W    = 20;
`endif

    logic clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    logic reset_n, bk_ena, load_req, save_req, autosave_en, osd_status;
    logic bram_wr, format_req, download, img_nz;
    logic bk_state, bk_loading, bk_pending, bk_err;

    bram_sd_seq_if sd_if ();

    bram_sd_seq #(.SECTORS(SECTORS), .FMT_N(FMT_N), .TO_W(TO_W)) dut (
        .clk_sys    (clk_sys),
        .reset_n    (reset_n),
        .bk_ena     (bk_ena),
        .load_req   (load_req),
        .save_req   (save_req),
        .autosave_en(autosave_en),
        .osd_status (osd_status),
        .bram_wr    (bram_wr),
        .format_req (format_req),
        .download   (download),
        .img_nz     (img_nz),
        .sd         (sd_if),
        .bk_state   (bk_state),
        .bk_loading (bk_loading),
        .bk_pending (bk_pending),
        .bk_err     (bk_err)
    );

    typedef struct {
        bit          is_write;
        int unsigned lba;
    } sect_t;

    sect_t       exp_sect[$];
    int unsigned exp_fmt[$];
    int          vectors     = 0;
    int          miscompares = 0;
    bit          resp_en     = 1'b1;
    bit          m_pend      = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
        else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    // Reference model: a transfer moves every sector of the image, in order.
    task automatic expect_xfer(input bit is_load);
        for (int i = 0; i < SECTORS; i++) begin
            sect_t e;
            e.is_write = ~is_load;
            e.lba      = i;
            exp_sect.push_back(e);
        end
    endtask

    task automatic expect_format();
        for (int i = 0; i < FMT_N; i++) exp_fmt.push_back(i);
    endtask

    // mask bit0 load, bit1 save, bit2 format
    task automatic pulse_req(input logic [2:0] mask);
        @(negedge clk_sys);
        load_req   = mask[0];
        save_req   = mask[1];
        format_req = mask[2];
        repeat (2) @(negedge clk_sys);
        load_req   = 1'b0;
        save_req   = 1'b0;
        format_req = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        repeat (4) @(negedge clk_sys);
        while ((exp_sect.size() != 0 || exp_fmt.size() != 0 || bk_state || sd_if.fmt_we)
               && n < 3000) begin
            @(negedge clk_sys);
            n++;
        end
        check({name, "_done"}, (n < 3000), 1);
        repeat (12) @(negedge clk_sys);
    endtask

    task automatic poke_bram(input bit osd);
        @(negedge clk_sys);
        osd_status = osd;
        bram_wr    = 1'b1;
        @(negedge clk_sys);
        bram_wr    = 1'b0;
        osd_status = 1'b0;
    endtask

    task automatic cart_download(input bit nz);
        @(negedge clk_sys);
        img_nz   = nz;
        download = 1'b1;
        repeat (3) @(negedge clk_sys);
        download = 1'b0;
    endtask

    // hps_io-like responder
    initial begin
        sd_if.sd_ack = 1'b0;
        forever begin
            @(posedge clk_sys);
            #1;
            if (resp_en && reset_n && (sd_if.sd_rd || sd_if.sd_wr)) begin
                repeat (5) @(negedge clk_sys);
                sd_if.sd_ack = 1'b1;
                repeat (3) @(negedge clk_sys);
                sd_if.sd_ack = 1'b0;
                repeat (2) @(negedge clk_sys);
            end
        end
    end

    // Monitor / scoreboard
    initial begin
        bit prev_req;
        bit cur_req;
        sect_t e;
        int unsigned f;
        prev_req = 1'b0;
        forever begin
            @(posedge clk_sys);
            #1;
            cur_req = sd_if.sd_rd | sd_if.sd_wr;
            if (cur_req && !prev_req) begin
                if (exp_sect.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_req: got lba %0d rd %0b wr %0b, required no request",
                             sd_if.sd_lba, sd_if.sd_rd, sd_if.sd_wr);
                end else begin
                    e = exp_sect.pop_front();
                    check("req_rd_wr_loading", {29'd0, sd_if.sd_rd, sd_if.sd_wr, bk_loading},
                          e.is_write ? 32'd2 : 32'd5);
                    check("req_lba", sd_if.sd_lba, e.lba);
                    check("req_bk_state", bk_state, 1);
                end
            end
            if (sd_if.fmt_we) begin
                if (exp_fmt.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_fmt_we: got addr %0d, required no strobe", sd_if.fmt_addr);
                end else begin
                    f = exp_fmt.pop_front();
                    check("fmt_addr", {28'd0, bk_state, sd_if.fmt_addr}, f);
                end
            end
            prev_req = cur_req;
        end
    end

    initial begin
        #5ms;
        $display("FAIL global_timeout: simulation still running, required finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n = 1'b0; bk_ena = 1'b0; load_req = 1'b0; save_req = 1'b0;
        autosave_en = 1'b0; osd_status = 1'b0; bram_wr = 1'b0; format_req = 1'b0;
        download = 1'b0; img_nz = 1'b0;

        // ---- reset state ----
        repeat (3) @(negedge clk_sys);
        check("rst_bk_state",   bk_state, 0);
        check("rst_bk_loading", bk_loading, 0);
        check("rst_bk_pending", bk_pending, 0);
        check("rst_bk_err",     bk_err, 0);
        check("rst_sd_rd_wr",   {sd_if.sd_rd, sd_if.sd_wr}, 0);
        check("rst_sd_lba",     sd_if.sd_lba, 0);
        check("rst_fmt",        {sd_if.fmt_we, sd_if.fmt_addr}, 0);
        reset_n = 1'b1;
        repeat (3) @(negedge clk_sys);

        // ---- manual save ----
        bk_ena = 1'b1;
        expect_xfer(1'b0);
        pulse_req(3'b010);
        wait_done("save");
        check("save_end_state", {bk_state, bk_loading}, 0);

        // ---- auto-load after download ----
        expect_xfer(1'b1);
        cart_download(1'b1);
        @(posedge clk_sys);
        #1;
        check("autoload_loading", bk_loading, 1);
        check("autoload_rd",      sd_if.sd_rd, 1);
        check("autoload_lba",     sd_if.sd_lba, 0);
        wait_done("autoload");
        cart_download(1'b0);
        repeat (10) @(negedge clk_sys);
        check("autoload_nz0_idle", {bk_state, bk_loading}, 0);

        // ---- autosave ----
        autosave_en = 1'b1;
        poke_bram(1'b0);
        check("pending_set", bk_pending, 1);
        expect_xfer(1'b0);
        @(negedge clk_sys);
        osd_status = 1'b1;
        repeat (2) @(negedge clk_sys);
        check("autosave_pending_clr", bk_pending, 0);
        check("autosave_active", bk_state, 1);
        wait_done("autosave");
        @(negedge clk_sys);
        bram_wr = 1'b1;
        @(negedge clk_sys);
        bram_wr = 1'b0;
        @(negedge clk_sys);
        check("pending_osd_open", bk_pending, 0);
        osd_status  = 1'b0;
        autosave_en = 1'b0;

        // ---- simultaneous load+save, then format during the transfer ----
        expect_xfer(1'b1);
        pulse_req(3'b011);
        repeat (30) @(negedge clk_sys);
        expect_format();
        pulse_req(3'b100);
        wait_done("load_fmt");

`ifdef BKSEQ_TIMEOUT_EN
        // ---- watchdog abort ----
        begin
            sect_t e;
            int n = 0;
            resp_en    = 1'b0;
            e.is_write = 1'b1;
            e.lba      = 0;
            exp_sect.push_back(e);
            pulse_req(3'b010);
            while (!bk_err && n < 400) begin
                @(negedge clk_sys);
                n++;
            end
            check("timeout_bk_err",   bk_err, 1);
            check("timeout_bk_state", {bk_state, sd_if.sd_wr, sd_if.sd_rd}, 0);
            resp_en = 1'b1;
            repeat (4) @(negedge clk_sys);
            expect_xfer(1'b0);
            pulse_req(3'b010);
            check("timeout_err_clr", bk_err, 0);
            wait_done("timeout_resave");
        end
`endif

        // ---- reset in the middle of sector 7 ----
        begin
            int n = 0;
            for (int i = 0; i < 8; i++) begin
                sect_t e;
                e.is_write = 1'b1;
                e.lba      = i;
                exp_sect.push_back(e);
            end
            pulse_req(3'b010);
            while (!(sd_if.sd_wr && sd_if.sd_lba == 7) && n < 1000) begin
                @(negedge clk_sys);
                n++;
            end
            check("rst_mid_reached_lba7", (n < 1000), 1);
            reset_n = 1'b0;
            #1;
            check("rst_mid_rd_wr", {sd_if.sd_rd, sd_if.sd_wr}, 0);
            check("rst_mid_state", {bk_state, bk_loading, bk_pending}, 0);
            check("rst_mid_lba",   sd_if.sd_lba, 0);
            repeat (3) @(negedge clk_sys);
            reset_n = 1'b1;
            repeat (40) @(negedge clk_sys);
            check("rst_mid_stays_idle", {bk_state, sd_if.sd_rd, sd_if.sd_wr}, 0);
            check("rst_mid_queue_left", exp_sect.size(), 0);
            m_pend = 1'b0;
        end

        // ---- randomized operations ----
        for (int it = 0; it < 24; it++) begin
            int op;
            bit osd, nz, wr;
            bk_ena = ($urandom_range(0, 3) != 0);
            osd    = $urandom_range(0, 1);
            wr     = $urandom_range(0, 1);
            if (wr) begin
                poke_bram(osd);
                if (bk_ena && !osd) m_pend = 1'b1;
            end
            @(negedge clk_sys);
            check("rand_pending_pre", bk_pending, m_pend);
            op = $urandom_range(0, 3);
            case (op)
                0: begin
                    if (bk_ena) begin expect_xfer(1'b0); m_pend = 1'b0; end
                    pulse_req(3'b010);
                end
                1: begin
                    if (bk_ena) begin expect_xfer(1'b1); m_pend = 1'b0; end
                    pulse_req(3'b001);
                end
                2: begin
                    nz = $urandom_range(0, 1);
                    if (nz && bk_ena) begin expect_xfer(1'b1); m_pend = 1'b0; end
                    cart_download(nz);
                end
                default: begin
                    expect_format();
                    pulse_req(3'b100);
                end
            endcase
            wait_done($sformatf("rand%0d_op%0d", it, op));
            check("rand_pending_post", bk_pending, m_pend);
        end

        check("final_sect_queue", exp_sect.size(), 0);
        check("final_fmt_queue",  exp_fmt.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
